// File: rtl/input_feeder_pkg.sv
// Shared parameters for the CNN input path and the activation feeder state encoding.
package input_feeder_pkg;

   localparam int N_DIM_ARRAY              = 8;
   localparam int INPUT_CHANNEL_DATA_WIDTH = 8;
   localparam int MAXIMUM_DILATION_BITS    = 3;
   localparam int ACT_ADDR_WIDTH           = 16;
   localparam int STEP_COUNT_WIDTH         = 8;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_LREQ,
      ST_LCAP,
      ST_LPULSE,
      ST_SREQ,
      ST_SCAP,
      ST_SPULSE,
      ST_DONE
   } feeder_state_t;

endpackage

// File: rtl/input_feeder.sv
// Activation fetch sequencer: one parallel-load word from SRAM, then a run of serial
// refill words, emitting the clear / load / enable strobes the input FIFO expects.
module input_feeder
   import input_feeder_pkg::*;
#(
   parameter int N  = N_DIM_ARRAY,
   parameter int DW = INPUT_CHANNEL_DATA_WIDTH,
   parameter int AW = ACT_ADDR_WIDTH,
   parameter int SW = MAXIMUM_DILATION_BITS,
   parameter int CW = STEP_COUNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [AW-1:0]        cfg_base,
   input  logic [CW-1:0]        cfg_steps,
   input  logic [SW-1:0]        cfg_shift,
   input  logic                 hold,
   output logic                 mem_req,
   output logic [AW-1:0]        mem_addr,
   input  logic [N*DW-1:0]      mem_rdata,
   output logic                 clear,
   output logic                 loading_in_parallel,
   output logic signed [DW-1:0] parallel_input_array [N],
   output logic                 enable,
   output logic signed [DW-1:0] serial_input [N],
   output logic [SW-1:0]        shift_input_buffer,
   output logic                 busy,
   output logic                 done
);

   // A shift can never consume more lanes than one word holds.
   localparam int             SHIFT_MAX   = (N < (2**SW) - 1) ? N : (2**SW) - 1;
   localparam logic [SW-1:0]  SHIFT_CLAMP = SW'(SHIFT_MAX);

   feeder_state_t state_q, state_d;

   logic [AW-1:0] base_q, base_d;
   logic [CW-1:0] steps_q, steps_d;
   logic [SW-1:0] shift_q, shift_d;
   logic [CW-1:0] step_cnt_q, step_cnt_d;

   logic signed [DW-1:0] par_q [N];
   logic signed [DW-1:0] ser_q [N];
   logic signed [DW-1:0] rdata_lanes [N];

   logic start_accept;
   logic sreq_fire;

   assign start_accept = (state_q == ST_IDLE) && start;
   assign sreq_fire    = (state_q == ST_SREQ) && !hold;

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values of its inputs, independent of process ordering.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // NOTE: every always_comb output gets a default first; a missing branch would
   // otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start) state_d = ST_CLEAR;
         ST_CLEAR:  state_d = ST_LREQ;
         ST_LREQ:   if (!hold) state_d = ST_LCAP;
         ST_LCAP:   state_d = ST_LPULSE;
         ST_LPULSE: state_d = (steps_q != '0) ? ST_SREQ : ST_DONE;
         ST_SREQ:   if (!hold) state_d = ST_SCAP;
         ST_SCAP:   state_d = ST_SPULSE;
         ST_SPULSE: state_d = (step_cnt_q < steps_q) ? ST_SREQ : ST_DONE;
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      mem_req             = 1'b0;
      mem_addr            = '0;
      clear               = 1'b0;
      loading_in_parallel = 1'b0;
      enable              = 1'b0;
      done                = 1'b0;
      busy                = (state_q != ST_IDLE);
      case (state_q)
         ST_CLEAR:  clear = 1'b1;
         ST_LREQ: begin
            mem_req  = !hold;
            mem_addr = base_q;
         end
         ST_SREQ: begin
            mem_req  = !hold;
            // step_cnt_q counts refills already issued; this one is base + k, k from 1.
            mem_addr = base_q + AW'(step_cnt_q) + AW'(1);
         end
         ST_LPULSE: loading_in_parallel = 1'b1;
         ST_SPULSE: enable = 1'b1;
         ST_DONE:   done = 1'b1;
         default:   ;
      endcase
   end

   always_comb begin
      base_d     = base_q;
      steps_d    = steps_q;
      shift_d    = shift_q;
      step_cnt_d = step_cnt_q;
      if (start_accept) begin
         base_d     = cfg_base;
         steps_d    = cfg_steps;
         shift_d    = (cfg_shift > SHIFT_CLAMP) ? SHIFT_CLAMP : cfg_shift;
         step_cnt_d = '0;
      end else if (sreq_fire) begin
         step_cnt_d = step_cnt_q + CW'(1);
      end
   end

   always_comb begin
      for (int i = 0; i < N; i++) rdata_lanes[i] = mem_rdata[i*DW +: DW];
   end

   // NOTE: the data registers are reset because the FIFO side must see zeros after
   // reset; these are flops, not a RAM, so the reset costs nothing structural.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         base_q     <= '0;
         steps_q    <= '0;
         shift_q    <= '0;
         step_cnt_q <= '0;
         for (int i = 0; i < N; i++) begin
            par_q[i] <= '0;
            ser_q[i] <= '0;
         end
      end else begin
         base_q     <= base_d;
         steps_q    <= steps_d;
         shift_q    <= shift_d;
         step_cnt_q <= step_cnt_d;
         if (state_q == ST_LCAP) begin
            for (int i = 0; i < N; i++) par_q[i] <= rdata_lanes[i];
         end
         if (state_q == ST_SCAP) begin
            for (int i = 0; i < N; i++) ser_q[i] <= rdata_lanes[i];
         end
      end
   end

   assign parallel_input_array = par_q;
   assign serial_input         = ser_q;
   assign shift_input_buffer   = shift_q;

endmodule

// File: tb/tb_input_feeder.sv
// Self-checking bench for input_feeder: table of sequences scored against an event
// queue built from the configured timing, plus reset and restart corner cases.
module tb_input_feeder;

   localparam int N  = 4;
   localparam int DW = 16;
   localparam int AW = 16;
   localparam int SW = 3;
   localparam int CW = 8;
   localparam int WW = N * DW;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 start;
   logic [AW-1:0]        cfg_base;
   logic [CW-1:0]        cfg_steps;
   logic [SW-1:0]        cfg_shift;
   logic                 hold;
   logic                 mem_req;
   logic [AW-1:0]        mem_addr;
   logic [WW-1:0]        mem_rdata = '0;
   logic                 clear;
   logic                 loading_in_parallel;
   logic signed [DW-1:0] parallel_input_array [N];
   logic                 enable;
   logic signed [DW-1:0] serial_input [N];
   logic [SW-1:0]        shift_input_buffer;
   logic                 busy;
   logic                 done;

   logic [WW-1:0] par_flat, ser_flat;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   input_feeder #(.N(N), .DW(DW), .AW(AW), .SW(SW), .CW(CW)) dut (
      .clk                  (clk),
      .reset                (reset),
      .start                (start),
      .cfg_base             (cfg_base),
      .cfg_steps            (cfg_steps),
      .cfg_shift            (cfg_shift),
      .hold                 (hold),
      .mem_req              (mem_req),
      .mem_addr             (mem_addr),
      .mem_rdata            (mem_rdata),
      .clear                (clear),
      .loading_in_parallel  (loading_in_parallel),
      .parallel_input_array (parallel_input_array),
      .enable               (enable),
      .serial_input         (serial_input),
      .shift_input_buffer   (shift_input_buffer),
      .busy                 (busy),
      .done                 (done)
   );

   always_comb begin
      par_flat = '0;
      ser_flat = '0;
      for (int i = 0; i < N; i++) begin
         par_flat[i*DW +: DW] = parallel_input_array[i];
         ser_flat[i*DW +: DW] = serial_input[i];
      end
   end

   // Activation SRAM model: lane i of word A holds A*16+i.
   function automatic logic [WW-1:0] mem_word(input logic [AW-1:0] a);
      logic [WW-1:0] w;
      for (int i = 0; i < N; i++) w[i*DW +: DW] = DW'(32'(a) * 16 + i);
      return w;
   endfunction

   always @(posedge clk) if (mem_req) mem_rdata <= mem_word(mem_addr);

   typedef enum int {EV_REQ, EV_LOAD, EV_SER, EV_DONE} ev_kind_t;
   typedef struct {
      ev_kind_t      kind;
      int            cyc;
      logic [AW-1:0] addr;
      logic [WW-1:0] data;
   } ev_t;
   ev_t sb[$];

   typedef struct {
      logic [AW-1:0] base;
      logic [CW-1:0] steps;
      logic [SW-1:0] shift;
      int            hold_from;
      int            hold_len;
      int            restart_at;
      logic [SW-1:0] exp_shift;
      int            exp_done;
   } vec_t;
   vec_t vecs [6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   function automatic bit in_hold(input int c, input int hf, input int hl);
      return (hl > 0) && (c >= hf) && (c < hf + hl);
   endfunction

   // Expected event timeline derived from the configured sequence timing.
   task automatic expect_seq(input logic [AW-1:0] base, input logic [CW-1:0] steps,
                             input int hf, input int hl);
      int t, last;
      logic [AW-1:0] a;
      t = 2;
      while (in_hold(t, hf, hl)) t++;
      sb.push_back(ev_t'{EV_REQ, t, base, '0});
      sb.push_back(ev_t'{EV_LOAD, t + 2, '0, mem_word(base)});
      last = t + 2;
      for (int j = 1; j <= int'(steps); j++) begin
         a = base + AW'(j);
         t = last + 1;
         while (in_hold(t, hf, hl)) t++;
         sb.push_back(ev_t'{EV_REQ, t, a, '0});
         sb.push_back(ev_t'{EV_SER, t + 2, '0, mem_word(a)});
         last = t + 2;
      end
      sb.push_back(ev_t'{EV_DONE, last + 1, '0, '0});
   endtask

   task automatic take_event(input string tag, input ev_kind_t kind, input int cyc,
                             input logic [AW-1:0] addr, input logic [WW-1:0] data);
      ev_t e;
      if (sb.size() == 0) begin
         check({tag, "_unexpected_event_queue_size"}, 64'(sb.size()), 64'(1));
      end else begin
         e = sb.pop_front();
         check({tag, "_ev_kind"}, 64'(int'(kind)), 64'(int'(e.kind)));
         check({tag, "_ev_cycle"}, 64'(cyc), 64'(e.cyc));
         if (kind == EV_REQ) check({tag, "_mem_addr"}, 64'(addr), 64'(e.addr));
         if (kind == EV_LOAD || kind == EV_SER) check({tag, "_data"}, 64'(data), 64'(e.data));
      end
   endtask

   task automatic run_seq(input string tag, input vec_t v);
      int cyc, done_cyc, clear_cyc, clear_cnt, busy_bad, last_pulse;
      bit overlap;
      expect_seq(v.base, v.steps, v.hold_from, v.hold_len);
      done_cyc = -1; clear_cyc = -1; clear_cnt = 0; busy_bad = 0; last_pulse = -10; overlap = 0;
      @(negedge clk);
      cfg_base = v.base; cfg_steps = v.steps; cfg_shift = v.shift; hold = 1'b0; start = 1'b1;
      cyc = 0;
      while (done_cyc < 0 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            cfg_base  = v.base ^ 16'h0F0F;
            cfg_steps = v.steps + 8'd5;
            cfg_shift = ~v.shift;
         end
         start = (v.restart_at > 0) && (cyc == v.restart_at || cyc == v.restart_at + 3);
         hold  = in_hold(cyc, v.hold_from, v.hold_len);
         #1;
         if (clear) begin clear_cnt++; clear_cyc = cyc; end
         if (busy !== 1'b1) busy_bad++;
         if (loading_in_parallel && enable) overlap = 1'b1;
         if ((loading_in_parallel || enable) && last_pulse == cyc - 1) overlap = 1'b1;
         if (loading_in_parallel || enable) last_pulse = cyc;
         if (mem_req)             take_event(tag, EV_REQ, cyc, mem_addr, '0);
         if (loading_in_parallel) take_event(tag, EV_LOAD, cyc, '0, par_flat);
         if (enable)              take_event(tag, EV_SER, cyc, '0, ser_flat);
         if (done) begin
            take_event(tag, EV_DONE, cyc, '0, '0);
            check({tag, "_shift"}, 64'(shift_input_buffer), 64'(v.exp_shift));
            done_cyc = cyc;
         end
      end
      start = 1'b0;
      hold  = 1'b0;
      check({tag, "_done_seen"}, 64'(done_cyc >= 0), 64'(1));
      check({tag, "_done_cycle"}, 64'(done_cyc), 64'(v.exp_done));
      check({tag, "_clear_cycle"}, 64'((clear_cnt == 1) ? clear_cyc : -1), 64'(1));
      check({tag, "_busy_low_cycles"}, 64'(busy_bad), 64'(0));
      check({tag, "_load_enable_overlap"}, 64'(overlap), 64'(0));
      check({tag, "_events_left"}, 64'(sb.size()), 64'(0));
      sb.delete();
      @(negedge clk);
      #1;
      check({tag, "_idle_busy"}, 64'(busy), 64'(0));
      check({tag, "_idle_shift"}, 64'(shift_input_buffer), 64'(v.exp_shift));
   endtask

   initial begin
      int quiet_bad;
      vec_t v;

      //             base      steps shift hf hl rs  exp_sh done
      vecs[0] = '{16'h0010, 8'd2, 3'd3, 0, 0, 0, 3'd3, 11};
      vecs[1] = '{16'h0020, 8'd0, 3'd2, 0, 0, 0, 3'd2, 5};
      vecs[2] = '{16'h0040, 8'd1, 3'd1, 5, 3, 0, 3'd1, 11};
      vecs[3] = '{16'hFFFF, 8'd1, 3'd7, 0, 0, 0, 3'd4, 8};
      vecs[4] = '{16'h1234, 8'd3, 3'd4, 2, 2, 3, 3'd4, 16};
      vecs[5] = '{16'h0100, 8'd1, 3'd5, 0, 0, 0, 3'd4, 8};

      reset = 1'b0; start = 1'b0; hold = 1'b0;
      cfg_base = '0; cfg_steps = '0; cfg_shift = '0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      #1;
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_ctrl", 64'({mem_req, clear, loading_in_parallel, enable, done}), 64'(0));
      check("rst_addr", 64'(mem_addr), 64'(0));
      check("rst_shift", 64'(shift_input_buffer), 64'(0));
      check("rst_par", par_flat, 64'(0));
      check("rst_ser", ser_flat, 64'(0));

      for (int i = 0; i < 6; i++) run_seq($sformatf("vec%0d", i), vecs[i]);

      // Reset asserted mid-sequence at cycle 6.
      @(negedge clk);
      cfg_base = 16'h0010; cfg_steps = 8'd2; cfg_shift = 3'd3; start = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      reset = 1'b0;
      @(negedge clk);
      #1;
      check("midrst_busy", 64'(busy), 64'(0));
      check("midrst_ctrl", 64'({mem_req, clear, loading_in_parallel, enable, done}), 64'(0));
      check("midrst_addr", 64'(mem_addr), 64'(0));
      check("midrst_shift", 64'(shift_input_buffer), 64'(0));
      check("midrst_par", par_flat, 64'(0));
      check("midrst_ser", ser_flat, 64'(0));
      @(negedge clk);
      reset = 1'b1;
      quiet_bad = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         #1;
         if (busy || done || mem_req) quiet_bad++;
      end
      check("midrst_quiet_after", 64'(quiet_bad), 64'(0));

      v = '{16'h0030, 8'd2, 3'd2, 0, 0, 0, 3'd2, 11};
      run_seq("after_rst", v);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
